hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller and scheduler for the five-stage RV32I core. It sits beside the F/D/E/M/W stage blocks and drives the stall, flush and forwarding controls for every pipeline register, including the decode stage. It also freezes the whole pipeline while a variable-latency data memory access in M is outstanding, with a timeout that raises a sticky error. Cycle counters for stalls and branch flushes give performance visibility.

## Interface
- TIMEOUT, 16: max cycles an M-stage memory access may wait for ack before error (2..65535)
- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- Rs1D_i, Rs2D_i  in  5 each  source regs of instruction in D
- Rs1E_i, Rs2E_i  in  5 each  source regs of instruction in E
- RdE_i  in  5  dest reg in E
- ResultSrcE_i  in  2  result select in E; 2'b01 = load
- PCSrcE_i  in  1  branch taken / jump resolved in E
- RdM_i, RdW_i  in  5 each  dest regs in M, W
- RegWriteM_i, RegWriteW_i  in  1 each  write enables in M, W
- MemReqM_i  in  1  M-stage instruction accesses data memory
- MemAckM_i  in  1  data memory completes the access this cycle
- StallF_o, StallD_o, StallE_o, StallM_o  out  1 each  hold stage register
- FlushD_o, FlushE_o, FlushW_o  out  1 each  insert bubble into stage register
- ForwardAE_o, ForwardBE_o  out  2 each  00 regfile, 01 from W, 10 from M
- MemErr_o  out  1  sticky memory-timeout error
- StallCnt_o  out  32  cycles with StallF_o high
- FlushCnt_o  out  32  cycles with branch-induced FlushE_o

## Operation
- FSM states: IDLE, MEM_WAIT, ERROR.
- IDLE: if MemReqM_i & !MemAckM_i, go to MEM_WAIT with wait counter = 1. Otherwise stay in IDLE.
- MEM_WAIT: if MemAckM_i, go to IDLE. Else if the wait counter equals TIMEOUT, go to ERROR and set MemErr_o. Else increment the wait counter.
- ERROR: absorbing until rst. MemErr_o = 1 and the freeze is held permanently.
- Freeze condition:
  - (IDLE & MemReqM_i & !MemAckM_i), or
  - (MEM_WAIT & !MemAckM_i), or
  - ERROR.
- During freeze:
  - StallF/D/E/M = 1 and FlushW = 1.
  - FlushD and FlushE are forced to 0.
  - Load-use detection is masked.
- Ack cycle: there is no freeze, so the normal rules below apply in the same cycle.
- Load-use, only when not frozen and PCSrcE_i = 0: ResultSrcE_i == 01 & RdE_i != 0 & (RdE_i == Rs1D_i | RdE_i == Rs2D_i) gives StallF = StallD = 1 and FlushE = 1.
- Branch, only when not frozen: PCSrcE_i gives FlushD = FlushE = 1 and StallF = StallD = 0. Branch overrides load-use.
- Forwarding A, evaluated every cycle regardless of freeze:
  - 10 if RegWriteM_i & RdM_i != 0 & RdM_i == Rs1E_i;
  - else 01 if RegWriteW_i & RdW_i != 0 & RdW_i == Rs1E_i;
  - else 00.
  - M has priority over W.
- Forwarding B: same rules as A, using Rs2E_i.
- x0 never forwards and never triggers load-use.
- Counters:
  - StallCnt_o increments in each cycle where StallF_o = 1.
  - FlushCnt_o increments in each non-frozen cycle where PCSrcE_i = 1.
  - Both are 32-bit unsigned and wrap from 0xFFFFFFFF to 0.

## Timing
- Stall, flush and forward outputs are combinational from the current inputs and FSM state. There is zero-cycle latency, so the response lands in the same cycle as the hazard.
- FSM state, wait counter, MemErr_o and both counters are registered and update on the clk rising edge.
- The rst assertion takes effect at the next edge:
  - state = IDLE, wait counter = 0, MemErr_o = 0, StallCnt_o = FlushCnt_o = 0.
  - This holds even mid-MEM_WAIT or in ERROR.
- With rst high, all combinational outputs still follow the rules using state IDLE.
- Output values after reset with all inputs 0: every stall/flush output = 0, ForwardAE_o = ForwardBE_o = 00.
- Ack in the same cycle as the request: no freeze and no state change.
- Error boundary: timeout fires on the edge where the counter equals TIMEOUT and ack is low, i.e. after TIMEOUT+1 frozen cycles in total. An ack in that cycle wins and the FSM returns to IDLE.
- Counter increments are suppressed in the cycle rst is high.

## Test plan
- Forwarding: RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5, Rs2E=0 -> ForwardAE=10, ForwardBE=00. Then RegWriteM=0 -> ForwardAE=01.
- Load-use: ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle and StallCnt increments by 1. Same stimulus with RdE=0 -> no stall.
- Branch plus load-use together: PCSrcE=1 with the load-use condition true -> FlushD=FlushE=1, StallF=StallD=0, FlushCnt +1.
- Memory wait: MemReqM=1, ack low for 3 cycles, then high -> 3 cycles of StallF/D/E/M=1 with FlushW=1; ack cycle has no freeze; StallCnt=3. PCSrcE=1 held throughout -> flushes asserted only in the ack cycle.
- Timeout with TIMEOUT=4: MemReqM=1 and ack never asserted -> MemErr_o=1 after 5 frozen cycles, freeze persists, and rst clears everything to reset values on the next edge.
- Counter wrap: preload via 2^32 StallF cycles (or a force in the bench) -> StallCnt wraps 0xFFFFFFFF to 0x00000000.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller for the five-stage RV32I core.
//
// Drives stall / flush / forwarding controls for the F/D/E/M/W pipeline
// registers, freezes the whole pipeline while a variable-latency data memory
// access in M is outstanding, and raises a sticky error if that access waits
// longer than TIMEOUT cycles. Two free-running 32-bit counters report cycles
// spent stalling the fetch stage and cycles lost to branch flushes.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   Rs1D_i, Rs2D_i           source registers of the instruction in D
//   Rs1E_i, Rs2E_i           source registers of the instruction in E
//   RdE_i, ResultSrcE_i      destination / result select in E (01 = load)
//   PCSrcE_i                 branch taken / jump resolved in E
//   RdM_i, RegWriteM_i       destination / write enable in M
//   RdW_i, RegWriteW_i       destination / write enable in W
//   MemReqM_i, MemAckM_i     M-stage data memory request / completion
//   StallF_o..StallM_o       hold the stage register
//   FlushD_o, FlushE_o,
//   FlushW_o                 insert a bubble into the stage register
//   ForwardAE_o, ForwardBE_o 00 regfile, 01 from W, 10 from M
//   MemErr_o                 sticky memory-timeout error
//   StallCnt_o, FlushCnt_o   stall-cycle and branch-flush-cycle counters
module hazard_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1D_i,
  input  logic [4:0]  Rs2D_i,
  input  logic [4:0]  Rs1E_i,
  input  logic [4:0]  Rs2E_i,
  input  logic [4:0]  RdE_i,
  input  logic [1:0]  ResultSrcE_i,
  input  logic        PCSrcE_i,
  input  logic [4:0]  RdM_i,
  input  logic [4:0]  RdW_i,
  input  logic        RegWriteM_i,
  input  logic        RegWriteW_i,
  input  logic        MemReqM_i,
  input  logic        MemAckM_i,
  output logic        StallF_o,
  output logic        StallD_o,
  output logic        StallE_o,
  output logic        StallM_o,
  output logic        FlushD_o,
  output logic        FlushE_o,
  output logic        FlushW_o,
  output logic [1:0]  ForwardAE_o,
  output logic [1:0]  ForwardBE_o,
  output logic        MemErr_o,
  output logic [31:0] StallCnt_o,
  output logic [31:0] FlushCnt_o
);

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t      state_reg, state_next, state_eff;
  logic [15:0] wait_cnt_reg, wait_cnt_next;
  logic        mem_err_reg, mem_err_next;
  logic [31:0] stall_cnt_reg, flush_cnt_reg;
  logic        frozen;
  logic        load_use;
  logic        branch;

  // While rst is held the combinational outputs behave as if the FSM were
  // already back in IDLE, even though the register only clears on the edge.
  assign state_eff = rst ? IDLE : state_reg;

  // ---------------------------------------------------------------------
  // Memory-wait FSM: next state and freeze decision
  // ---------------------------------------------------------------------
  always_comb begin
    state_next    = state_eff;
    wait_cnt_next = wait_cnt_reg;
    mem_err_next  = mem_err_reg;
    frozen        = 1'b0;
    case (state_eff)
      IDLE: begin
        // A request acked in the same cycle completes without any freeze.
        if (MemReqM_i && !MemAckM_i) begin
          frozen        = 1'b1;
          state_next    = MEM_WAIT;
          wait_cnt_next = 16'd1;
        end
      end
      MEM_WAIT: begin
        // An ack in the timeout cycle still wins over the error.
        if (MemAckM_i) begin
          state_next    = IDLE;
          wait_cnt_next = 16'd0;
        end else begin
          frozen = 1'b1;
          if (wait_cnt_reg == TIMEOUT_W) begin
            state_next   = ERROR;
            mem_err_next = 1'b1;
          end else begin
            wait_cnt_next = wait_cnt_reg + 16'd1;
          end
        end
      end
      ERROR: begin
        frozen       = 1'b1;
        mem_err_next = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Stall / flush generation
  // ---------------------------------------------------------------------
  // A taken branch squashes the D instruction anyway, so load-use is only
  // relevant when no redirect is happening; both are masked by a freeze.
  assign branch   = !frozen && PCSrcE_i;
  assign load_use = !frozen && !PCSrcE_i && (ResultSrcE_i == 2'b01) &&
                    (RdE_i != 5'd0) &&
                    ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));

  always_comb begin
    StallF_o = 1'b0;
    StallD_o = 1'b0;
    StallE_o = 1'b0;
    StallM_o = 1'b0;
    FlushD_o = 1'b0;
    FlushE_o = 1'b0;
    FlushW_o = 1'b0;
    if (frozen) begin
      // Hold F..M and let W retire bubbles so nothing writes twice.
      StallF_o = 1'b1;
      StallD_o = 1'b1;
      StallE_o = 1'b1;
      StallM_o = 1'b1;
      FlushW_o = 1'b1;
    end else if (branch) begin
      FlushD_o = 1'b1;
      FlushE_o = 1'b1;
    end else if (load_use) begin
      StallF_o = 1'b1;
      StallD_o = 1'b1;
      FlushE_o = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Forwarding: one identical mux per E-stage source operand, M over W.
  // ---------------------------------------------------------------------
  logic [4:0] rs_e [2];
  logic [1:0] fwd  [2];

  assign rs_e[0] = Rs1E_i;
  assign rs_e[1] = Rs2E_i;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd[gi] =
        (RegWriteM_i && (RdM_i != 5'd0) && (RdM_i == rs_e[gi])) ? 2'b10 :
        (RegWriteW_i && (RdW_i != 5'd0) && (RdW_i == rs_e[gi])) ? 2'b01 :
                                                                  2'b00;
    end
  endgenerate

  assign ForwardAE_o = fwd[0];
  assign ForwardBE_o = fwd[1];

  // ---------------------------------------------------------------------
  // State, error flag and performance counters
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= 16'd0;
      mem_err_reg   <= 1'b0;
      stall_cnt_reg <= 32'd0;
      flush_cnt_reg <= 32'd0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      mem_err_reg  <= mem_err_next;
      // Both counters wrap naturally at 2^32.
      if (StallF_o) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
      if (branch) begin
        flush_cnt_reg <= flush_cnt_reg + 32'd1;
      end
    end
  end

  assign MemErr_o   = mem_err_reg;
  assign StallCnt_o = stall_cnt_reg;
  assign FlushCnt_o = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl -- self-checking bench for hazard_ctrl (TIMEOUT = 4).
// Directed scenarios check fixed expected values; a randomized run checks
// every output each cycle against a behavioural model that tracks how many
// consecutive frozen cycles an M-stage access has spent waiting.
module tb_hazard_ctrl;

  localparam int unsigned TO = 4;

  // Output vector layout: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,FwdA,FwdB}
  localparam logic [10:0] IDLE_VEC   = 11'b0000_000_00_00;
  localparam logic [10:0] FROZEN_VEC = 11'b1111_001_00_00;
  localparam logic [10:0] BRANCH_VEC = 11'b0000_110_00_00;
  localparam logic [10:0] LU_VEC     = 11'b1100_010_00_00;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i;
  logic [1:0]  ResultSrcE_i;
  logic        PCSrcE_i, RegWriteM_i, RegWriteW_i, MemReqM_i, MemAckM_i;
  logic        StallF_o, StallD_o, StallE_o, StallM_o;
  logic        FlushD_o, FlushE_o, FlushW_o;
  logic [1:0]  ForwardAE_o, ForwardBE_o;
  logic        MemErr_o;
  logic [31:0] StallCnt_o, FlushCnt_o;
  logic [10:0] dut_vec;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: consecutive frozen cycles of the outstanding access, error flag, counters.
  int          m_age  = 0;
  bit          m_err  = 1'b0;
  logic [31:0] m_scnt = 32'd0;
  logic [31:0] m_fcnt = 32'd0;

  always #5 clk = ~clk;

  hazard_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .Rs1D_i(Rs1D_i), .Rs2D_i(Rs2D_i), .Rs1E_i(Rs1E_i), .Rs2E_i(Rs2E_i),
    .RdE_i(RdE_i), .ResultSrcE_i(ResultSrcE_i), .PCSrcE_i(PCSrcE_i),
    .RdM_i(RdM_i), .RdW_i(RdW_i), .RegWriteM_i(RegWriteM_i), .RegWriteW_i(RegWriteW_i),
    .MemReqM_i(MemReqM_i), .MemAckM_i(MemAckM_i),
    .StallF_o(StallF_o), .StallD_o(StallD_o), .StallE_o(StallE_o), .StallM_o(StallM_o),
    .FlushD_o(FlushD_o), .FlushE_o(FlushE_o), .FlushW_o(FlushW_o),
    .ForwardAE_o(ForwardAE_o), .ForwardBE_o(ForwardBE_o),
    .MemErr_o(MemErr_o), .StallCnt_o(StallCnt_o), .FlushCnt_o(FlushCnt_o)
  );

  assign dut_vec = {StallF_o, StallD_o, StallE_o, StallM_o,
                    FlushD_o, FlushE_o, FlushW_o, ForwardAE_o, ForwardBE_o};

  // ------------------------------------------------------------------
  // Reference model
  // ------------------------------------------------------------------
  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (RegWriteM_i && RdM_i != 0 && RdM_i == rs) return 2'b10;
    if (RegWriteW_i && RdW_i != 0 && RdW_i == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit ref_frozen();
    int age;
    bit err;
    age = rst ? 0 : m_age;
    err = rst ? 1'b0 : m_err;
    return err || (!MemAckM_i && (age > 0 || MemReqM_i));
  endfunction

  function automatic logic [10:0] ref_vec();
    bit fr, br, lu;
    fr = ref_frozen();
    br = !fr && PCSrcE_i;
    lu = !fr && !PCSrcE_i && ResultSrcE_i == 2'b01 && RdE_i != 0 &&
         (RdE_i == Rs1D_i || RdE_i == Rs2D_i);
    return {fr | lu, fr | lu, fr, fr, br, br | lu, fr, ref_fwd(Rs1E_i), ref_fwd(Rs2E_i)};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_age  <= 0;
      m_err  <= 1'b0;
      m_scnt <= 32'd0;
      m_fcnt <= 32'd0;
    end else begin
      if (ref_frozen() || (ResultSrcE_i == 2'b01 && !PCSrcE_i && RdE_i != 0 &&
                           (RdE_i == Rs1D_i || RdE_i == Rs2D_i)))
        m_scnt <= m_scnt + 32'd1;
      if (!ref_frozen() && PCSrcE_i) m_fcnt <= m_fcnt + 32'd1;
      if (!m_err) begin
        if (ref_frozen()) begin
          m_age <= m_age + 1;
          if (m_age + 1 == TO + 1) m_err <= 1'b1;
        end else begin
          m_age <= 0;
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Stimulus helpers (no checking)
  // ------------------------------------------------------------------
  task automatic clear_inputs();
    Rs1D_i = 0; Rs2D_i = 0; Rs1E_i = 0; Rs2E_i = 0; RdE_i = 0; RdM_i = 0; RdW_i = 0;
    ResultSrcE_i = 0; PCSrcE_i = 0; RegWriteM_i = 0; RegWriteW_i = 0;
    MemReqM_i = 0; MemAckM_i = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ------------------------------------------------------------------
  // Scenarios
  // ------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    // Leave the FSM mid-wait with a non-zero stall count, then reset.
    MemReqM_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    MemReqM_i = 1'b0;
    rst = 1'b1;
    #2;
    n_cmp++;
    if (dut_vec !== IDLE_VEC) begin
      n_bad++; $display("FAIL reset_comb_during_rst: got %b expected %b", dut_vec, IDLE_VEC);
    end
    @(negedge clk);
    rst = 1'b0;
    #2;
    n_cmp++;
    if (dut_vec !== IDLE_VEC) begin
      n_bad++; $display("FAIL reset_outputs: got %b expected %b", dut_vec, IDLE_VEC);
    end
    n_cmp++;
    if (StallCnt_o !== 32'd0 || FlushCnt_o !== 32'd0 || MemErr_o !== 1'b0) begin
      n_bad++; $display("FAIL reset_regs: got scnt=%h fcnt=%h err=%b expected 0/0/0",
                        StallCnt_o, FlushCnt_o, MemErr_o);
    end
    $display("test_reset done");
  endtask

  task automatic test_forwarding();
    do_reset();
    RegWriteM_i = 1; RdM_i = 5; RegWriteW_i = 1; RdW_i = 5; Rs1E_i = 5; Rs2E_i = 0;
    #2;
    n_cmp++;
    if (ForwardAE_o !== 2'b10 || ForwardBE_o !== 2'b00) begin
      n_bad++; $display("FAIL fwd_m_priority: got A=%b B=%b expected A=10 B=00", ForwardAE_o, ForwardBE_o);
    end
    RegWriteM_i = 0;
    #2;
    n_cmp++;
    if (ForwardAE_o !== 2'b01) begin
      n_bad++; $display("FAIL fwd_from_w: got A=%b expected 01", ForwardAE_o);
    end
    RegWriteM_i = 1; RdM_i = 0; RdW_i = 0; Rs1E_i = 0; Rs2E_i = 9;
    #2;
    n_cmp++;
    if (ForwardAE_o !== 2'b00 || ForwardBE_o !== 2'b00) begin
      n_bad++; $display("FAIL fwd_x0: got A=%b B=%b expected 00/00", ForwardAE_o, ForwardBE_o);
    end
    RdM_i = 9; Rs1E_i = 3; RdW_i = 3;
    #2;
    n_cmp++;
    if (ForwardAE_o !== 2'b01 || ForwardBE_o !== 2'b10) begin
      n_bad++; $display("FAIL fwd_split: got A=%b B=%b expected 01/10", ForwardAE_o, ForwardBE_o);
    end
    $display("test_forwarding done");
  endtask

  task automatic test_load_use();
    do_reset();
    ResultSrcE_i = 2'b01; RdE_i = 7; Rs2D_i = 7;
    #2;
    n_cmp++;
    if (dut_vec !== LU_VEC) begin
      n_bad++; $display("FAIL load_use: got %b expected %b", dut_vec, LU_VEC);
    end
    @(negedge clk);
    RdE_i = 0; Rs2D_i = 0;
    #2;
    n_cmp++;
    if (dut_vec !== IDLE_VEC) begin
      n_bad++; $display("FAIL load_use_x0: got %b expected %b", dut_vec, IDLE_VEC);
    end
    n_cmp++;
    if (StallCnt_o !== 32'd1) begin
      n_bad++; $display("FAIL load_use_cnt: got %0d expected 1", StallCnt_o);
    end
    @(negedge clk);
    RdE_i = 12; Rs1D_i = 12; ResultSrcE_i = 2'b00;
    #2;
    n_cmp++;
    if (dut_vec !== IDLE_VEC || StallCnt_o !== 32'd1) begin
      n_bad++; $display("FAIL non_load: got %b cnt=%0d expected %b cnt=1", dut_vec, StallCnt_o, IDLE_VEC);
    end
    $display("test_load_use done");
  endtask

  task automatic test_branch_load_use();
    do_reset();
    ResultSrcE_i = 2'b01; RdE_i = 7; Rs1D_i = 7; PCSrcE_i = 1;
    #2;
    n_cmp++;
    if (dut_vec !== BRANCH_VEC) begin
      n_bad++; $display("FAIL branch_over_lu: got %b expected %b", dut_vec, BRANCH_VEC);
    end
    @(negedge clk);
    clear_inputs();
    #2;
    n_cmp++;
    if (FlushCnt_o !== 32'd1 || StallCnt_o !== 32'd0) begin
      n_bad++; $display("FAIL branch_cnt: got fcnt=%0d scnt=%0d expected 1/0", FlushCnt_o, StallCnt_o);
    end
    $display("test_branch_load_use done");
  endtask

  task automatic test_mem_wait();
    do_reset();
    MemReqM_i = 1; PCSrcE_i = 1;
    for (int i = 0; i < 3; i++) begin
      #2;
      n_cmp++;
      if (dut_vec !== FROZEN_VEC) begin
        n_bad++; $display("FAIL mem_wait_freeze[%0d]: got %b expected %b", i, dut_vec, FROZEN_VEC);
      end
      @(negedge clk);
    end
    MemAckM_i = 1;
    #2;
    n_cmp++;
    if (dut_vec !== BRANCH_VEC) begin
      n_bad++; $display("FAIL mem_ack_cycle: got %b expected %b", dut_vec, BRANCH_VEC);
    end
    @(negedge clk);
    clear_inputs();
    #2;
    n_cmp++;
    if (StallCnt_o !== 32'd3 || FlushCnt_o !== 32'd1 || MemErr_o !== 1'b0) begin
      n_bad++; $display("FAIL mem_wait_cnt: got scnt=%0d fcnt=%0d err=%b expected 3/1/0",
                        StallCnt_o, FlushCnt_o, MemErr_o);
    end
    // Ack in the request cycle: no freeze, and no lingering wait afterwards.
    MemReqM_i = 1; MemAckM_i = 1;
    #2;
    n_cmp++;
    if (dut_vec !== IDLE_VEC) begin
      n_bad++; $display("FAIL same_cycle_ack: got %b expected %b", dut_vec, IDLE_VEC);
    end
    @(negedge clk);
    clear_inputs();
    #2;
    n_cmp++;
    if (dut_vec !== IDLE_VEC) begin
      n_bad++; $display("FAIL after_same_cycle_ack: got %b expected %b", dut_vec, IDLE_VEC);
    end
    $display("test_mem_wait done");
  endtask

  task automatic test_timeout();
    do_reset();
    MemReqM_i = 1;
    for (int i = 0; i < TO + 1; i++) begin
      #2;
      n_cmp++;
      if (dut_vec !== FROZEN_VEC || MemErr_o !== 1'b0) begin
        n_bad++; $display("FAIL timeout_pre[%0d]: got %b err=%b expected %b err=0", i, dut_vec, MemErr_o, FROZEN_VEC);
      end
      @(negedge clk);
    end
    MemReqM_i = 0; PCSrcE_i = 1; ResultSrcE_i = 2'b01; RdE_i = 4; Rs1D_i = 4;
    #2;
    n_cmp++;
    if (MemErr_o !== 1'b1 || dut_vec !== FROZEN_VEC) begin
      n_bad++; $display("FAIL timeout_err: got %b err=%b expected %b err=1", dut_vec, MemErr_o, FROZEN_VEC);
    end
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    #2;
    n_cmp++;
    if (dut_vec !== IDLE_VEC) begin
      n_bad++; $display("FAIL error_rst_comb: got %b expected %b", dut_vec, IDLE_VEC);
    end
    @(negedge clk);
    rst = 1'b0;
    #2;
    n_cmp++;
    if (MemErr_o !== 1'b0 || StallCnt_o !== 32'd0 || FlushCnt_o !== 32'd0) begin
      n_bad++; $display("FAIL error_rst_regs: got err=%b scnt=%0d fcnt=%0d expected 0/0/0",
                        MemErr_o, StallCnt_o, FlushCnt_o);
    end
    // Ack arriving in the timeout cycle wins.
    MemReqM_i = 1;
    for (int i = 0; i < TO; i++) @(negedge clk);
    MemAckM_i = 1;
    #2;
    n_cmp++;
    if (dut_vec !== IDLE_VEC) begin
      n_bad++; $display("FAIL ack_at_timeout: got %b expected %b", dut_vec, IDLE_VEC);
    end
    @(negedge clk);
    clear_inputs();
    #2;
    n_cmp++;
    if (MemErr_o !== 1'b0 || dut_vec !== IDLE_VEC || StallCnt_o !== TO) begin
      n_bad++; $display("FAIL after_ack_at_timeout: got %b err=%b scnt=%0d expected %b err=0 scnt=%0d",
                        dut_vec, MemErr_o, StallCnt_o, IDLE_VEC, TO);
    end
    $display("test_timeout done");
  endtask

  task automatic test_counter_wrap();
    do_reset();
    force dut.stall_cnt_reg = 32'hFFFF_FFFF;
    m_scnt = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_reg;
    ResultSrcE_i = 2'b01; RdE_i = 3; Rs1D_i = 3;
    #1;
    n_cmp++;
    if (StallCnt_o !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL wrap_preload: got %h expected ffffffff", StallCnt_o);
    end
    @(negedge clk);
    clear_inputs();
    #2;
    n_cmp++;
    if (StallCnt_o !== 32'h0000_0000) begin
      n_bad++; $display("FAIL wrap: got %h expected 00000000", StallCnt_o);
    end
    $display("test_counter_wrap done");
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rst          = ($urandom_range(0, 99) < 2);
      Rs1D_i       = 5'($urandom_range(0, 3));
      Rs2D_i       = 5'($urandom_range(0, 3));
      Rs1E_i       = 5'($urandom_range(0, 3));
      Rs2E_i       = 5'($urandom_range(0, 3));
      RdE_i        = 5'($urandom_range(0, 3));
      RdM_i        = 5'($urandom_range(0, 3));
      RdW_i        = 5'($urandom_range(0, 3));
      ResultSrcE_i = 2'($urandom_range(0, 3));
      PCSrcE_i     = ($urandom_range(0, 3) == 0);
      RegWriteM_i  = 1'($urandom_range(0, 1));
      RegWriteW_i  = 1'($urandom_range(0, 1));
      MemReqM_i    = ($urandom_range(0, 4) == 0);
      MemAckM_i    = ($urandom_range(0, 9) < 6);
      #2;
      n_cmp++;
      if (dut_vec !== ref_vec()) begin
        n_bad++; $display("FAIL rnd_comb[%0d]: got %b expected %b", c, dut_vec, ref_vec());
      end
      n_cmp++;
      if (MemErr_o !== m_err) begin
        n_bad++; $display("FAIL rnd_err[%0d]: got %b expected %b", c, MemErr_o, m_err);
      end
      n_cmp++;
      if (StallCnt_o !== m_scnt || FlushCnt_o !== m_fcnt) begin
        n_bad++; $display("FAIL rnd_cnt[%0d]: got scnt=%0d fcnt=%0d expected %0d/%0d",
                          c, StallCnt_o, FlushCnt_o, m_scnt, m_fcnt);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_load_use();
    test_mem_wait();
    test_timeout();
    test_counter_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
